// File: rtl/ft_arb_pkg.sv
// Shared encodings for the fault-tolerant result arbiter.
// Holds the status/state enums, the two-rail codes and a saturating increment helper.
package ft_arb_pkg;

  typedef enum logic [2:0] {
    StatOk       = 3'd0,
    StatDegraded = 3'd1,
    StatDisagree = 3'd2,
    StatInputErr = 3'd3,
    StatFail     = 3'd4
  } status_e;

  typedef enum logic [1:0] {
    StNormal = 2'd0,
    StXOnly  = 2'd1,
    StYOnly  = 2'd2,
    StFailed = 2'd3
  } state_e;

  localparam logic [1:0] TR_OK  = 2'b01;
  localparam logic [1:0] TR_MIS = 2'b10;
  localparam logic [1:0] TR_INP = 2'b11;
  localparam logic [1:0] TR_CHK = 2'b00;

  function automatic logic [3:0] sat_inc(input logic [3:0] v, input logic [3:0] lim);
    return (v >= lim) ? lim : v + 4'd1;
  endfunction

endpackage

// File: rtl/ft_result_arbiter_if.sv
// Bundle of ALU-side inputs and registered result outputs for ft_result_arbiter.
// Optional R_PAR is present only when FT_ARB_PARITY_OUT_EN is defined.
interface ft_result_arbiter_if #(
  parameter int unsigned CNT_W = 4
) ();
  logic             IN_VALID;
  logic [2:0]       X_SUM;
  logic             XC;
  logic [1:0]       XE;
  logic [2:0]       Y_SUM;
  logic             YC;
  logic [1:0]       YE;
  logic             CLR_FAULT;
  logic             OUT_VALID;
  logic [2:0]       R_SUM;
  logic             RC;
  logic [2:0]       R_STATUS;
  logic [1:0]       STATE;
  logic [CNT_W-1:0] ERR_CNT;
  logic             ALARM;
`ifdef FT_ARB_PARITY_OUT_EN
  logic             R_PAR;
`endif

  modport master (
    output IN_VALID, X_SUM, XC, XE, Y_SUM, YC, YE, CLR_FAULT,
`ifdef FT_ARB_PARITY_OUT_EN
    input  R_PAR,
`endif
    input  OUT_VALID, R_SUM, RC, R_STATUS, STATE, ERR_CNT, ALARM
  );

  modport slave (
    input  IN_VALID, X_SUM, XC, XE, Y_SUM, YC, YE, CLR_FAULT,
`ifdef FT_ARB_PARITY_OUT_EN
    output R_PAR,
`endif
    output OUT_VALID, R_SUM, RC, R_STATUS, STATE, ERR_CNT, ALARM
  );
endinterface

// File: rtl/ft_rail_decode.sv
// Combinational decode of one two-rail error pair into ok / bad / input-error flags.
module ft_rail_decode
  import ft_arb_pkg::*;
(
  input  logic [1:0] pair_i,
  output logic       is_ok_o,
  output logic       is_bad_o,
  output logic       is_inp_o
);
  always_comb begin
    is_ok_o  = (pair_i == TR_OK);
    is_inp_o = (pair_i == TR_INP);
    is_bad_o = (pair_i == TR_MIS) || (pair_i == TR_CHK);
  end
endmodule

// File: rtl/ft_result_arbiter.sv
// Registered arbiter over the duplicated X/Y ALU result channels with per-channel quarantine.
// Define FT_ARB_PARITY_OUT_EN to add the R_PAR even-parity output.
module ft_result_arbiter
  import ft_arb_pkg::*;
#(
  parameter int unsigned FAIL_THRESH = 3,
  parameter int unsigned CNT_W       = 4
) (
  input logic                 CLK,
  input logic                 RST,
  ft_result_arbiter_if.slave  bus
);
  localparam logic [3:0] Thresh = 4'(FAIL_THRESH);
  localparam logic [CNT_W-1:0] ErrMax = {CNT_W{1'b1}};

  logic x_ok, x_bad, x_inp, y_ok, y_bad, y_inp;

  ft_rail_decode u_dec_x (.pair_i(bus.XE), .is_ok_o(x_ok), .is_bad_o(x_bad), .is_inp_o(x_inp));
  ft_rail_decode u_dec_y (.pair_i(bus.YE), .is_ok_o(y_ok), .is_bad_o(y_bad), .is_inp_o(y_inp));

  state_e           state_q, state_d;
  status_e          status_q, status_d;
  logic [3:0]       xcnt_q, xcnt_d, ycnt_q, ycnt_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic [2:0]       sum_q, sum_d;
  logic             rc_q, rc_d;
  logic             ovld_q, ovld_d;
  logic             upd;  // result register takes new data this cycle

  always_comb begin
    state_d  = state_q;
    status_d = status_q;
    xcnt_d   = xcnt_q;
    ycnt_d   = ycnt_q;
    err_d    = err_q;
    sum_d    = sum_q;
    rc_d     = rc_q;
    ovld_d   = bus.IN_VALID;
    upd      = 1'b0;

    if (bus.CLR_FAULT) begin
      state_d = StNormal;
      xcnt_d  = '0;
      ycnt_d  = '0;
      err_d   = '0;
      ovld_d  = 1'b0;
    end else if (bus.IN_VALID) begin
      if (state_q == StFailed) begin
        status_d = StatFail;
      end else if (x_inp || y_inp) begin
        // A code 11 on either rail wins, even on a quarantined channel.
        status_d = StatInputErr;
      end else begin
        unique case (state_q)
          StNormal: begin
            if (x_ok && y_ok) begin
              if ({bus.X_SUM, bus.XC} == {bus.Y_SUM, bus.YC}) begin
                status_d = StatOk;
                upd      = 1'b1;
                xcnt_d   = '0;
                ycnt_d   = '0;
              end else begin
                status_d = StatDisagree;
              end
            end else if (x_ok) begin
              status_d = StatDegraded;
              upd      = 1'b1;
              xcnt_d   = '0;
              ycnt_d   = sat_inc(ycnt_q, Thresh);
            end else if (y_ok) begin
              status_d = StatDegraded;
              upd      = 1'b1;
              ycnt_d   = '0;
              xcnt_d   = sat_inc(xcnt_q, Thresh);
            end else begin
              status_d = StatFail;
              xcnt_d   = sat_inc(xcnt_q, Thresh);
              ycnt_d   = sat_inc(ycnt_q, Thresh);
            end
            if (xcnt_d == Thresh && ycnt_d == Thresh) state_d = StFailed;
            else if (xcnt_d == Thresh)                state_d = StYOnly;
            else if (ycnt_d == Thresh)                state_d = StXOnly;
          end
          StXOnly: begin
            if (x_ok) begin
              status_d = StatDegraded;
              upd      = 1'b1;
              xcnt_d   = '0;
            end else if (x_bad) begin
              status_d = StatFail;
              xcnt_d   = sat_inc(xcnt_q, Thresh);
              if (xcnt_d == Thresh) state_d = StFailed;
            end
          end
          StYOnly: begin
            if (y_ok) begin
              status_d = StatDegraded;
              upd      = 1'b1;
              ycnt_d   = '0;
            end else if (y_bad) begin
              status_d = StatFail;
              ycnt_d   = sat_inc(ycnt_q, Thresh);
              if (ycnt_d == Thresh) state_d = StFailed;
            end
          end
          default: status_d = StatFail;
        endcase
      end

      if (upd) begin
        // In NORMAL with X ok, X is the source; otherwise the surviving Y.
        if ((state_q == StYOnly) || (state_q == StNormal && !x_ok)) begin
          sum_d = bus.Y_SUM;
          rc_d  = bus.YC;
        end else begin
          sum_d = bus.X_SUM;
          rc_d  = bus.XC;
        end
      end

      if (status_d != StatOk && err_q != ErrMax) err_d = err_q + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= StNormal;
      status_q <= StatOk;
      xcnt_q   <= '0;
      ycnt_q   <= '0;
      err_q    <= '0;
      sum_q    <= '0;
      rc_q     <= 1'b0;
      ovld_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      status_q <= status_d;
      xcnt_q   <= xcnt_d;
      ycnt_q   <= ycnt_d;
      err_q    <= err_d;
      sum_q    <= sum_d;
      rc_q     <= rc_d;
      ovld_q   <= ovld_d;
    end
  end

`ifdef FT_ARB_PARITY_OUT_EN
  logic par_q, par_d;

  always_comb begin
    par_d = par_q;
    if (upd) par_d = ^{rc_d, sum_d};
  end

  always_ff @(posedge CLK) begin
    if (RST) par_q <= 1'b0;
    else     par_q <= par_d;
  end

  assign bus.R_PAR = par_q;
`endif

  assign bus.OUT_VALID = ovld_q;
  assign bus.R_SUM     = sum_q;
  assign bus.RC        = rc_q;
  assign bus.R_STATUS  = status_q;
  assign bus.STATE     = state_q;
  assign bus.ERR_CNT   = err_q;
  assign bus.ALARM     = (state_q != StNormal);

endmodule

// File: tb/tb_ft_result_arbiter.sv
// Directed self-checking bench for ft_result_arbiter (FAIL_THRESH=3, CNT_W=4).
module tb_ft_result_arbiter;
  logic CLK;
  logic RST;
  int   n_cmp;
  int   n_err;

  ft_result_arbiter_if #(.CNT_W(4)) bus ();

  ft_result_arbiter #(.FAIL_THRESH(3), .CNT_W(4)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic step(input logic v, input logic [2:0] xs, input logic xc, input logic [1:0] xe,
                      input logic [2:0] ys, input logic yc, input logic [1:0] ye,
                      input logic clr);
    bus.IN_VALID  = v;
    bus.X_SUM     = xs;
    bus.XC        = xc;
    bus.XE        = xe;
    bus.Y_SUM     = ys;
    bus.YC        = yc;
    bus.YE        = ye;
    bus.CLR_FAULT = clr;
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;

    // Reset
    RST = 1'b1;
    step(1'b1, 3'd7, 1'b1, 2'b01, 3'd7, 1'b1, 2'b01, 1'b0);
    chk("rst_ov", 8'(bus.OUT_VALID), 8'd0);
    chk("rst_sum", 8'(bus.R_SUM), 8'd0);
    chk("rst_rc", 8'(bus.RC), 8'd0);
    chk("rst_status", 8'(bus.R_STATUS), 8'd0);
    chk("rst_state", 8'(bus.STATE), 8'd0);
    chk("rst_err", 8'(bus.ERR_CNT), 8'd0);
    chk("rst_alarm", 8'(bus.ALARM), 8'd0);
`ifdef FT_ARB_PARITY_OUT_EN
    chk("rst_par", 8'(bus.R_PAR), 8'd0);
`endif
    RST = 1'b0;

    // Both ok, equal
    step(1'b1, 3'd5, 1'b0, 2'b01, 3'd5, 1'b0, 2'b01, 1'b0);
    chk("ok_ov", 8'(bus.OUT_VALID), 8'd1);
    chk("ok_sum", 8'(bus.R_SUM), 8'd5);
    chk("ok_rc", 8'(bus.RC), 8'd0);
    chk("ok_status", 8'(bus.R_STATUS), 8'd0);
    chk("ok_state", 8'(bus.STATE), 8'd0);
    chk("ok_err", 8'(bus.ERR_CNT), 8'd0);
`ifdef FT_ARB_PARITY_OUT_EN
    chk("ok_par", 8'(bus.R_PAR), 8'd0);
`endif

    // X mismatch x3, Y=6 survives -> Y_ONLY
    step(1'b1, 3'd1, 1'b0, 2'b10, 3'd6, 1'b0, 2'b01, 1'b0);
    chk("xq1_sum", 8'(bus.R_SUM), 8'd6);
    chk("xq1_status", 8'(bus.R_STATUS), 8'd1);
    chk("xq1_state", 8'(bus.STATE), 8'd0);
    step(1'b1, 3'd1, 1'b0, 2'b10, 3'd6, 1'b0, 2'b01, 1'b0);
    chk("xq2_status", 8'(bus.R_STATUS), 8'd1);
    chk("xq2_state", 8'(bus.STATE), 8'd0);
    step(1'b1, 3'd1, 1'b0, 2'b10, 3'd6, 1'b0, 2'b01, 1'b0);
    chk("xq3_sum", 8'(bus.R_SUM), 8'd6);
    chk("xq3_status", 8'(bus.R_STATUS), 8'd1);
    chk("xq3_state", 8'(bus.STATE), 8'd2);
    chk("xq3_alarm", 8'(bus.ALARM), 8'd1);
    chk("xq3_err", 8'(bus.ERR_CNT), 8'd3);

    // In Y_ONLY: Y checker fault x3 -> FAILED; X (ok) ignored
    step(1'b1, 3'd2, 1'b0, 2'b01, 3'd3, 1'b0, 2'b00, 1'b0);
    chk("yf1_status", 8'(bus.R_STATUS), 8'd4);
    chk("yf1_sum", 8'(bus.R_SUM), 8'd6);
    step(1'b1, 3'd2, 1'b0, 2'b01, 3'd3, 1'b0, 2'b00, 1'b0);
    chk("yf2_state", 8'(bus.STATE), 8'd2);
    step(1'b1, 3'd2, 1'b0, 2'b01, 3'd3, 1'b0, 2'b00, 1'b0);
    chk("yf3_status", 8'(bus.R_STATUS), 8'd4);
    chk("yf3_sum", 8'(bus.R_SUM), 8'd6);
    chk("yf3_state", 8'(bus.STATE), 8'd3);
    chk("yf3_err", 8'(bus.ERR_CNT), 8'd6);
    step(1'b1, 3'd2, 1'b0, 2'b01, 3'd2, 1'b0, 2'b01, 1'b0);
    chk("fl_status", 8'(bus.R_STATUS), 8'd4);
    chk("fl_state", 8'(bus.STATE), 8'd3);
    chk("fl_sum", 8'(bus.R_SUM), 8'd6);
    chk("fl_err", 8'(bus.ERR_CNT), 8'd7);

    // CLR_FAULT beats IN_VALID
    step(1'b1, 3'd1, 1'b0, 2'b01, 3'd1, 1'b0, 2'b01, 1'b1);
    chk("clr_state", 8'(bus.STATE), 8'd0);
    chk("clr_err", 8'(bus.ERR_CNT), 8'd0);
    chk("clr_ov", 8'(bus.OUT_VALID), 8'd0);
    chk("clr_sum", 8'(bus.R_SUM), 8'd6);
    chk("clr_status", 8'(bus.R_STATUS), 8'd4);
    chk("clr_alarm", 8'(bus.ALARM), 8'd0);

    // Y mismatch x3, X=5 carry 1 survives -> X_ONLY
    step(1'b1, 3'd5, 1'b1, 2'b01, 3'd0, 1'b0, 2'b10, 1'b0);
    step(1'b1, 3'd5, 1'b1, 2'b01, 3'd0, 1'b0, 2'b10, 1'b0);
    step(1'b1, 3'd5, 1'b1, 2'b01, 3'd0, 1'b0, 2'b10, 1'b0);
    chk("yq_sum", 8'(bus.R_SUM), 8'd5);
    chk("yq_rc", 8'(bus.RC), 8'd1);
    chk("yq_state", 8'(bus.STATE), 8'd1);
    chk("yq_err", 8'(bus.ERR_CNT), 8'd3);
`ifdef FT_ARB_PARITY_OUT_EN
    chk("yq_par", 8'(bus.R_PAR), 8'd1);
`endif
    step(1'b1, 3'd4, 1'b0, 2'b01, 3'd0, 1'b0, 2'b00, 1'b0);
    chk("xo_sum", 8'(bus.R_SUM), 8'd4);
    chk("xo_status", 8'(bus.R_STATUS), 8'd1);
    step(1'b1, 3'd6, 1'b0, 2'b01, 3'd0, 1'b0, 2'b11, 1'b0);
    chk("xo_inp_status", 8'(bus.R_STATUS), 8'd3);
    chk("xo_inp_sum", 8'(bus.R_SUM), 8'd4);
    chk("xo_inp_err", 8'(bus.ERR_CNT), 8'd5);
    step(1'b0, 3'd0, 1'b0, 2'b01, 3'd0, 1'b0, 2'b01, 1'b1);
    chk("clr2_state", 8'(bus.STATE), 8'd0);

    // INPUT_ERR leaves xcnt untouched
    step(1'b1, 3'd0, 1'b0, 2'b10, 3'd7, 1'b0, 2'b01, 1'b0);
    chk("ie1_sum", 8'(bus.R_SUM), 8'd7);
    chk("ie1_status", 8'(bus.R_STATUS), 8'd1);
    step(1'b1, 3'd1, 1'b0, 2'b11, 3'd1, 1'b0, 2'b01, 1'b0);
    chk("ie2_status", 8'(bus.R_STATUS), 8'd3);
    chk("ie2_sum", 8'(bus.R_SUM), 8'd7);
    step(1'b1, 3'd0, 1'b0, 2'b10, 3'd7, 1'b0, 2'b01, 1'b0);
    chk("ie3_state", 8'(bus.STATE), 8'd0);
    chk("ie3_err", 8'(bus.ERR_CNT), 8'd3);
    step(1'b1, 3'd2, 1'b0, 2'b01, 3'd2, 1'b0, 2'b01, 1'b0);
    chk("ie4_status", 8'(bus.R_STATUS), 8'd0);
    chk("ie4_sum", 8'(bus.R_SUM), 8'd2);
    step(1'b1, 3'd0, 1'b0, 2'b10, 3'd2, 1'b0, 2'b01, 1'b0);
    step(1'b1, 3'd0, 1'b0, 2'b10, 3'd2, 1'b0, 2'b01, 1'b0);
    chk("ie6_state", 8'(bus.STATE), 8'd0);
    chk("ie6_err", 8'(bus.ERR_CNT), 8'd5);
    step(1'b1, 3'd2, 1'b0, 2'b01, 3'd2, 1'b0, 2'b01, 1'b0);
    chk("ie7_status", 8'(bus.R_STATUS), 8'd0);

    // Disagree
    step(1'b1, 3'd3, 1'b0, 2'b01, 3'd4, 1'b0, 2'b01, 1'b0);
    chk("dis_status", 8'(bus.R_STATUS), 8'd2);
    chk("dis_sum", 8'(bus.R_SUM), 8'd2);
    chk("dis_err", 8'(bus.ERR_CNT), 8'd6);
    chk("dis_state", 8'(bus.STATE), 8'd0);

    // Idle holds
    step(1'b0, 3'd7, 1'b1, 2'b00, 3'd7, 1'b1, 2'b00, 1'b0);
    chk("idle_ov", 8'(bus.OUT_VALID), 8'd0);
    chk("idle_status", 8'(bus.R_STATUS), 8'd2);
    chk("idle_err", 8'(bus.ERR_CNT), 8'd6);

    // Both bad x3 -> simultaneous threshold -> FAILED
    step(1'b1, 3'd1, 1'b0, 2'b00, 3'd1, 1'b0, 2'b00, 1'b0);
    step(1'b1, 3'd1, 1'b0, 2'b00, 3'd1, 1'b0, 2'b00, 1'b0);
    chk("bb2_state", 8'(bus.STATE), 8'd0);
    step(1'b1, 3'd1, 1'b0, 2'b00, 3'd1, 1'b0, 2'b00, 1'b0);
    chk("bb3_state", 8'(bus.STATE), 8'd3);
    chk("bb3_status", 8'(bus.R_STATUS), 8'd4);
    chk("bb3_err", 8'(bus.ERR_CNT), 8'd9);
    for (int i = 0; i < 17; i++) step(1'b1, 3'd1, 1'b0, 2'b00, 3'd1, 1'b0, 2'b00, 1'b0);
    chk("sat_err", 8'(bus.ERR_CNT), 8'd15);
    chk("sat_sum", 8'(bus.R_SUM), 8'd2);

    // Reset mid-stream
    RST = 1'b1;
    step(1'b1, 3'd5, 1'b0, 2'b01, 3'd5, 1'b0, 2'b01, 1'b0);
    chk("rst2_ov", 8'(bus.OUT_VALID), 8'd0);
    chk("rst2_status", 8'(bus.R_STATUS), 8'd0);
    chk("rst2_state", 8'(bus.STATE), 8'd0);
    chk("rst2_err", 8'(bus.ERR_CNT), 8'd0);
    chk("rst2_sum", 8'(bus.R_SUM), 8'd0);
    chk("rst2_alarm", 8'(bus.ALARM), 8'd0);
    RST = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
